// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: request size codes, FSM states, zero constants.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mem_ctrl_pkg;

    // Request size encodings carried on mem_sel_i
    localparam logic [1:0] MEM_NOP  = 2'd0;
    localparam logic [1:0] MEM_BYTE = 2'd1;
    localparam logic [1:0] MEM_HALF = 2'd2;
    localparam logic [1:0] MEM_WORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [7:0]  ZeroByte = 8'h00;

    // Number of bytes moved for a size code (0 for NOP)
    function automatic logic [2:0] size_bytes(input logic [1:0] sel);
        case (sel)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            MEM_WORD: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Load extension: picks BYTE/HALF/WORD from four little-endian bytes and sign/zero extends.
// Latency: combinational. Backpressure: none.
// Ports: sel (size code), sign (extend enable), data (bytes, [0] = lowest address), result.
module load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]      sel,
    input  logic            sign,
    input  logic [3:0][7:0] data,
    output logic [31:0]     result
);

    always_comb begin
        result = ZeroWord;
        case (sel)
            MEM_BYTE: result = {{24{sign & data[0][7]}}, data[0]};
            MEM_HALF: result = {{16{sign & data[1][7]}}, data[1], data[0]};
            MEM_WORD: result = data;
            default:  result = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory responder: arbitrates IF fetches and MEM loads/stores onto an 8-bit synchronous RAM, one byte per cycle.
// Latency (accept edge to done visible): loads N+1 cycles (2/3/5), stores N cycles (1/2/4); one DONE cycle follows.
// Backpressure: requesters hold a level req until their done pulse; nothing is accepted outside IDLE, MEM wins ties.
// Ports: clk/rst (sync, active-high); if_* fetch side; mem_* load/store side; ram_* byte-wide RAM port.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_sel_i,
    input  logic              mem_sign_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        sel;
    logic              we;
    logic              sign;
    logic              from_if;
    logic [3:0][7:0]   wdata;
    logic [2:0]        cnt;      // edges since acceptance, minus one
    logic [3:0][7:0]   rbytes;

    logic              mem_go;
    logic              if_go;
    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        len;
    logic [2:0]        nxt;
    logic [ADDR_W-1:0] nxt_addr;
    logic [1:0]        cap_idx;
    logic [3:0][7:0]   ext_bytes;
    logic [31:0]       ext_word;
    logic              unused_bits;

    assign mem_go   = mem_req_i && (mem_sel_i != MEM_NOP);
    assign if_go    = if_req_i && !mem_go;
    assign acc_addr = mem_go ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
    assign len      = size_bytes(sel);
    assign nxt      = cnt + 3'd1;
    // Wraps naturally modulo 2^ADDR_W
    assign nxt_addr = addr + ADDR_W'(nxt);
    // Byte arriving on ram_din_i this cycle belongs to position cnt-1
    assign cap_idx  = cnt[1:0] - 2'd1;

    // Upper request address bits are dropped; wdata byte 0 goes out straight from the input at accept.
    assign unused_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W], wdata[0]};

    // The final byte is used straight off the RAM port so the result lands on the same edge it arrives.
    always_comb begin
        ext_bytes          = rbytes;
        ext_bytes[cap_idx] = ram_din_i;
    end

    load_ext u_load_ext (
        .sel    (sel),
        .sign   (sign),
        .data   (ext_bytes),
        .result (ext_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr        <= '0;
            sel         <= MEM_NOP;
            we          <= 1'b0;
            sign        <= 1'b0;
            from_if     <= 1'b0;
            wdata       <= ZeroWord;
            cnt         <= 3'd0;
            rbytes      <= ZeroWord;
            if_done_o   <= 1'b0;
            if_inst_o   <= ZeroWord;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= ZeroWord;
            ram_dout_o  <= ZeroByte;
            ram_a_o     <= '0;
            ram_wr_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_go || if_go) begin
                        from_if <= if_go;
                        we      <= mem_go && mem_we_i;
                        sel     <= mem_go ? mem_sel_i : MEM_WORD;
                        sign    <= mem_go && mem_sign_i;
                        addr    <= acc_addr;
                        wdata   <= mem_wdata_i;
                        cnt     <= 3'd0;
                        // First byte address goes out on the accept edge itself
                        ram_a_o <= acc_addr;
                        if (mem_go && mem_we_i) begin
                            ram_dout_o <= mem_wdata_i[7:0];
                            ram_wr_o   <= 1'b1;
                            state      <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    cnt <= nxt;
                    if (nxt < len) begin
                        ram_a_o <= nxt_addr;
                    end
                    if ((cnt != 3'd0) && (cnt < len)) begin
                        rbytes[cap_idx] <= ram_din_i;
                    end
                    if (cnt == len) begin
                        ram_a_o <= '0;
                        if (from_if) begin
                            if_inst_o <= ext_word;
                            if_done_o <= 1'b1;
                        end else begin
                            mem_rdata_o <= ext_word;
                            mem_done_o  <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end

                ST_WRITE: begin
                    cnt <= nxt;
                    if (nxt < len) begin
                        ram_a_o    <= nxt_addr;
                        ram_dout_o <= wdata[nxt[1:0]];
                        ram_wr_o   <= 1'b1;
                    end else begin
                        ram_a_o    <= '0;
                        ram_dout_o <= ZeroByte;
                        ram_wr_o   <= 1'b0;
                        mem_done_o <= 1'b1;
                        state      <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Single-cycle pulse; requests are not looked at until IDLE
                    if_done_o  <= 1'b0;
                    mem_done_o <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM model, directed vector table, hand sequences, randomized ops vs memory model.
// Latency: n/a. Backpressure: requests held until done, dropped right after the pulse.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int          ADDR_W    = 17;
    localparam int          RAM_SIZE  = 1 << ADDR_W;
    localparam logic [31:0] ADDR_MASK = 32'h0001_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_sel;
    logic              mem_sign;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_done_o   (if_done),
        .if_inst_o   (if_inst),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_sel_i   (mem_sel),
        .mem_sign_i  (mem_sign),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_done_o  (mem_done),
        .mem_rdata_o (mem_rdata),
        .ram_din_i   (ram_din),
        .ram_dout_o  (ram_dout),
        .ram_a_o     (ram_a),
        .ram_wr_o    (ram_wr)
    );

    // Synchronous byte RAM with a backdoor write port and a write log
    logic [7:0]        ram   [0:RAM_SIZE-1];
    logic [7:0]        model [0:RAM_SIZE-1];
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_data;
    int                wr_total = 0;
    logic [ADDR_W-1:0] log_a [0:1023];
    logic [7:0]        log_d [0:1023];

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (ram_wr) begin
            ram[ram_a]               <= ram_dout;
            log_a[wr_total % 1024]   <= ram_a;
            log_d[wr_total % 1024]   <= ram_dout;
            wr_total                 <= wr_total + 1;
        end
        ram_din <= ram[ram_a];
    end

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] last_mem_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic int nbytes(input logic [1:0] sel);
        return (sel == MEM_BYTE) ? 1 : (sel == MEM_HALF) ? 2 : 4;
    endfunction

    // Reference load: little-endian gather from the model memory, wrap at 2^ADDR_W, then extend
    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input logic sign);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(model[(addr + 32'(i)) & ADDR_MASK]) << (8 * i));
        if (sign && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic bd_write(input logic [31:0] addr, input logic [7:0] data);
        bd_addr = addr[ADDR_W-1:0];
        bd_data = data;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we   = 1'b0;
        model[addr & ADDR_MASK] = data;
    endtask

    // One MEM transaction; lat = edges from accept to done visible, -1 on timeout
    task automatic do_mem(input logic we, input logic [1:0] sel, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat, output int wstart);
        @(negedge clk);
        wstart    = wr_total;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_sel   = sel;
        mem_sign  = sign;
        mem_addr  = addr;
        mem_wdata = wdata;
        lat       = -1;
        rdata     = 'x;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (mem_done) begin
                lat   = k;
                rdata = mem_rdata;
            end
        end
        mem_req = 1'b0;
        mem_sel = MEM_NOP;
        mem_we  = 1'b0;
        @(posedge clk); #1;
        check("mem_done width", {31'b0, mem_done}, 32'h0);
    endtask

    task automatic run_mem(input string name, input logic we, input logic [1:0] sel, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input int exp_lat);
        logic [31:0] rdata;
        int          lat, wstart, n;
        n = nbytes(sel);
        do_mem(we, sel, sign, addr, wdata, rdata, lat, wstart);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " rdata"}, rdata, exp_rdata);
        check({name, " write count"}, 32'(wr_total - wstart), 32'(we ? n : 0));
        if (we) begin
            for (int i = 0; i < n; i++) begin
                check({name, " write addr"}, 32'(log_a[(wstart + i) % 1024]), (addr + 32'(i)) & ADDR_MASK);
                check({name, " write data"}, 32'(log_d[(wstart + i) % 1024]), 32'(8'(wdata >> (8 * i))));
                model[(addr + 32'(i)) & ADDR_MASK] = 8'(wdata >> (8 * i));
            end
        end else begin
            last_mem_rdata = exp_rdata;
        end
    endtask

    task automatic run_if(input string name, input logic [31:0] addr, input logic [31:0] exp_inst);
        int          lat, wstart;
        logic [31:0] inst;
        @(negedge clk);
        wstart  = wr_total;
        if_req  = 1'b1;
        if_addr = addr;
        lat     = -1;
        inst    = 'x;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (if_done) begin
                lat  = k;
                inst = if_inst;
            end
        end
        if_req = 1'b0;
        @(posedge clk); #1;
        check({name, " if_done width"}, {31'b0, if_done}, 32'h0);
        check({name, " latency"}, 32'(lat), 32'd5);
        check({name, " inst"}, inst, exp_inst);
        check({name, " no writes"}, 32'(wr_total - wstart), 32'h0);
        check({name, " mem_rdata held"}, mem_rdata, last_mem_rdata);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] r_addr, r_wdata, exp_m, exp_i, got_m, got_i;
        logic [1:0]  r_sel;
        logic        r_we, r_sign;
        int          mem_at, if_at, mem_cnt, if_cnt, n, done_seen;

        vecs[0]  = '{1'b0, MEM_BYTE, 1'b1, 32'h0000_0020, 32'h0,          32'hFFFF_FF80, 2};
        vecs[1]  = '{1'b0, MEM_BYTE, 1'b0, 32'h0000_0020, 32'h0,          32'h0000_0080, 2};
        vecs[2]  = '{1'b1, MEM_HALF, 1'b0, 32'h0000_0040, 32'hAABB_CCDD,  32'h0000_0080, 2};
        vecs[3]  = '{1'b0, MEM_HALF, 1'b1, 32'h0000_0040, 32'h0,          32'hFFFF_CCDD, 3};
        vecs[4]  = '{1'b0, MEM_HALF, 1'b0, 32'h0000_0040, 32'h0,          32'h0000_CCDD, 3};
        vecs[5]  = '{1'b0, MEM_WORD, 1'b1, 32'h0000_0100, 32'h0,          32'h1234_5678, 5};
        vecs[6]  = '{1'b1, MEM_WORD, 1'b0, 32'h0001_FFFE, 32'hCAFE_F00D,  32'h1234_5678, 4};
        vecs[7]  = '{1'b0, MEM_WORD, 1'b0, 32'h0001_FFFE, 32'h0,          32'hCAFE_F00D, 5};
        vecs[8]  = '{1'b0, MEM_HALF, 1'b1, 32'h0001_FFFF, 32'h0,          32'hFFFF_FEF0, 3};
        vecs[9]  = '{1'b0, MEM_BYTE, 1'b1, 32'h0000_0041, 32'h0,          32'hFFFF_FFCC, 2};
        vecs[10] = '{1'b0, MEM_BYTE, 1'b0, 32'h0002_0020, 32'h0,          32'h0000_0080, 2};

        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_sel = MEM_NOP; mem_sign = 1'b0; mem_addr = '0; mem_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        last_mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Preload the windows the tests touch
        for (int a = 0; a < 32'h400; a++) bd_write(32'(a), 8'($urandom));
        for (int a = 32'h1FFF0; a < RAM_SIZE; a++) bd_write(32'(a), 8'($urandom));
        bd_write(32'h20, 8'h80);
        bd_write(32'h100, 8'h78); bd_write(32'h101, 8'h56);
        bd_write(32'h102, 8'h34); bd_write(32'h103, 8'h12);
        for (int a = 32'h300; a < 32'h304; a++) bd_write(32'(a), 8'hEE);

        @(negedge clk);
        check("reset if_done",   {31'b0, if_done}, 32'h0);
        check("reset if_inst",   if_inst, 32'h0);
        check("reset mem_done",  {31'b0, mem_done}, 32'h0);
        check("reset mem_rdata", mem_rdata, 32'h0);
        check("reset ram_a",     32'(ram_a), 32'h0);
        check("reset ram_wr",    {31'b0, ram_wr}, 32'h0);
        check("reset ram_dout",  32'(ram_dout), 32'h0);
        rst = 1'b0;

        run_if("if fetch 0x100", 32'h100, 32'h1234_5678);

        for (int i = 0; i < 11; i++)
            run_mem($sformatf("vec%0d", i), vecs[i].we, vecs[i].sel, vecs[i].sign,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_lat);

        // Simultaneous IF and MEM: MEM first, IF accepted after DONE plus one IDLE cycle
        exp_m = model_load(32'h40, 4, 1'b0);
        exp_i = model_load(32'h100, 4, 1'b0);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = MEM_WORD; mem_sign = 1'b0; mem_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h100;
        mem_at = -1; if_at = -1; mem_cnt = 0; if_cnt = 0; got_m = 'x; got_i = 'x;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (mem_done) begin mem_cnt++; mem_at = k; got_m = mem_rdata; mem_req = 1'b0; mem_sel = MEM_NOP; end
            if (if_done)  begin if_cnt++;  if_at = k;  got_i = if_inst;   if_req = 1'b0; end
        end
        check("arb mem done edge",  32'(mem_at), 32'd5);
        check("arb if done edge",   32'(if_at), 32'd12);
        check("arb mem done count", 32'(mem_cnt), 32'd1);
        check("arb if done count",  32'(if_cnt), 32'd1);
        check("arb mem rdata",      got_m, exp_m);
        check("arb if inst",        got_i, exp_i);
        last_mem_rdata = exp_m;

        // Reset in the middle of a WORD store after two bytes went out
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = MEM_WORD; mem_sign = 1'b0;
        mem_addr = 32'h300; mem_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        check("irq store byte0 addr", 32'(ram_a), 32'h300);
        check("irq store byte0 wr",   {31'b0, ram_wr}, 32'h1);
        check("irq store byte0 data", 32'(ram_dout), 32'h44);
        @(posedge clk); #1;
        check("irq store byte1 addr", 32'(ram_a), 32'h301);
        rst = 1'b1; mem_req = 1'b0; mem_sel = MEM_NOP; mem_we = 1'b0;
        @(posedge clk); #1;
        check("irq reset ram_wr",    {31'b0, ram_wr}, 32'h0);
        check("irq reset ram_a",     32'(ram_a), 32'h0);
        check("irq reset mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_done) done_seen++;
            @(posedge clk); #1;
        end
        check("irq no mem_done", 32'(done_seen), 32'h0);
        check("irq ram 0x300", 32'(ram[32'h300]), 32'h44);
        check("irq ram 0x301", 32'(ram[32'h301]), 32'h33);
        check("irq ram 0x302", 32'(ram[32'h302]), 32'hEE);
        check("irq ram 0x303", 32'(ram[32'h303]), 32'hEE);
        model[32'h300] = 8'h44;
        model[32'h301] = 8'h33;
        last_mem_rdata = 32'h0;
        run_mem("post reset load", 1'b0, MEM_WORD, 1'b0, 32'h300, 32'h0, 32'hEEEE_3344, 5);

        // Randomized ops against the model memory
        for (int t = 0; t < 80; t++) begin
            r_addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h3F8))
                                                 : 32'h1FFF0 + 32'($urandom_range(0, 15));
            r_addr = r_addr | ($urandom & 32'hFFFE_0000);
            if ($urandom_range(0, 4) == 0) begin
                run_if($sformatf("rnd%0d if", t), r_addr, model_load(r_addr, 4, 1'b0));
            end else begin
                r_we    = 1'($urandom_range(0, 1));
                r_sel   = 2'($urandom_range(1, 3));
                r_sign  = 1'($urandom_range(0, 1));
                r_wdata = $urandom;
                n       = nbytes(r_sel);
                run_mem($sformatf("rnd%0d mem", t), r_we, r_sel, r_sign, r_addr, r_wdata,
                        r_we ? last_mem_rdata : model_load(r_addr, n, r_sign),
                        r_we ? n : n + 1);
            end
        end

        for (int t = 0; t < 16; t++) begin
            r_addr = 32'($urandom_range(0, 32'h3FF));
            check($sformatf("final ram 0x%0h", r_addr), 32'(ram[r_addr]), 32'(model[r_addr]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
